// File: rtl/hova_clock_ctrl.sv
// hova_clock_ctrl
//   Builds the Hovalaag core clock (tt_clk) and reset (tt_rst_n) from the
//   12 MHz board clock. Supports free-run, single-period step,
//   whole-instruction step and PC breakpoint halt. It mirrors the core's
//   5-stage sequence and captures PC (stage 3) and output (stage 4) from tt_out.
//
// Ports
//   clk12MHz, reset      : board clock, synchronous active-high block reset
//   run_en               : level, free-run while high
//   step_btn, instr_btn  : async buttons, one period / to next stage-0 boundary
//   core_rst_btn         : async button, re-runs the core reset sequence
//   bp_en, bp_pc         : PC breakpoint
//   tt_out               : core output bus
//   tt_clk, tt_rst_n     : generated core clock / active-low reset (registered)
//   stage, pc, out_val   : mirrored stage, last captured PC and output
//   halted, busy         : sticky breakpoint hit, period/reset in progress
module hova_clock_ctrl #(
    parameter int DIV           = 6,
    parameter int RESET_CYCLES  = 2,
    parameter int DEBOUNCE_BITS = 17
) (
    input  logic       clk12MHz,
    input  logic       reset,
    input  logic       run_en,
    input  logic       step_btn,
    input  logic       instr_btn,
    input  logic       core_rst_btn,
    input  logic       bp_en,
    input  logic [7:0] bp_pc,
    input  logic [7:0] tt_out,
    output logic       tt_clk,
    output logic       tt_rst_n,
    output logic [2:0] stage,
    output logic [7:0] pc,
    output logic [7:0] out_val,
    output logic       halted,
    output logic       busy
);
    localparam int CW   = $clog2(DIV);
    localparam int NMAX = (RESET_CYCLES > 5) ? RESET_CYCLES : 5;
    localparam int LW   = $clog2(NMAX + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(DIV - 1);
    localparam logic [LW-1:0] RST_N    = LW'(RESET_CYCLES);

    typedef enum logic [1:0] {S_CORE_RST, S_HALT, S_STEP, S_RUN} state_t;
    typedef enum logic [1:0] {PH_IDLE, PH_HI, PH_LO} phase_t;

    // ---------------- buttons: sync, edge detect, lockout ----------------
    logic [2:0] btn, edge_d;
    assign btn = {core_rst_btn, instr_btn, step_btn};

    for (genvar i = 0; i < 3; i++) begin : g_btn
        logic s1_q, s2_q, prev_q, lock_q;
        logic [DEBOUNCE_BITS-1:0] lcnt_q;
        assign edge_d[i] = s2_q & ~prev_q & ~lock_q;
        always_ff @(posedge clk12MHz) begin
            if (reset) begin
                s1_q   <= 1'b0;
                s2_q   <= 1'b0;
                prev_q <= 1'b0;
                lock_q <= 1'b0;
                lcnt_q <= '0;
            end else begin
                s1_q   <= btn[i];
                s2_q   <= s1_q;
                prev_q <= s2_q;
                if (edge_d[i]) begin
                    lock_q <= 1'b1;
                    lcnt_q <= '0;
                end else if (lock_q) begin
                    lcnt_q <= lcnt_q + DEBOUNCE_BITS'(1);
                    if (lcnt_q == '1) lock_q <= 1'b0;
                end
            end
        end
    end

    // ---------------- period engine + mode FSM ----------------
    state_t          state_q, state_d;
    phase_t          ph_q;
    logic [CW-1:0]   cnt_q;
    logic [LW-1:0]   left_q, left_d;   // periods remaining, including the current one
    logic [2:0]      stage_q, per_stage_q, stage_inc;
    logic [7:0]      pc_q, out_q;
    logic            tt_clk_q, tt_rst_n_q, halted_q, busy_q, rst_req_q;
    logic            hi_end, lo_end, bp_hit, rst_pend;
    logic            start_n, start_r, to_halt, clr_halt;
    logic [LW-1:0]   instr_n;

    assign hi_end    = (ph_q == PH_HI) && (cnt_q == CNT_LAST);
    assign lo_end    = (ph_q == PH_LO) && (cnt_q == CNT_LAST);
    assign rst_pend  = rst_req_q | edge_d[2];
    assign stage_inc = (stage_q == 3'd4) ? 3'd0 : stage_q + 3'd1;
    assign instr_n   = (stage_q == 3'd0) ? LW'(5) : LW'(5) - LW'(stage_q);
    // per_stage_q is the stage the core executes during this period
    assign bp_hit    = lo_end && (per_stage_q == 3'd3) && bp_en && (tt_out == bp_pc);

    always_comb begin
        state_d  = state_q;
        left_d   = left_q;
        start_n  = 1'b0;
        start_r  = 1'b0;
        to_halt  = 1'b0;
        clr_halt = 1'b0;
        if (lo_end) begin
            if (rst_pend) begin
                start_r = 1'b1;
                state_d = S_CORE_RST;
                left_d  = RST_N;
            end else begin
                case (state_q)
                    S_CORE_RST, S_STEP: begin
                        if (left_q > LW'(1)) begin
                            start_r = (state_q == S_CORE_RST);
                            start_n = (state_q == S_STEP);
                            left_d  = left_q - LW'(1);
                        end else begin
                            to_halt = 1'b1;
                        end
                    end
                    S_RUN: begin
                        if (!run_en || halted_q || bp_hit) to_halt = 1'b1;
                        else start_n = 1'b1;
                    end
                    default: to_halt = 1'b1;
                endcase
            end
        end else if (ph_q == PH_IDLE) begin
            if (state_q != S_HALT) begin
                // first reset period after block reset
                start_r = 1'b1;
            end else if (rst_pend) begin
                start_r = 1'b1;
                state_d = S_CORE_RST;
                left_d  = RST_N;
            end else if (edge_d[0]) begin
                start_n  = 1'b1;
                clr_halt = 1'b1;
                state_d  = S_STEP;
                left_d   = LW'(1);
            end else if (edge_d[1]) begin
                start_n  = 1'b1;
                clr_halt = 1'b1;
                state_d  = S_STEP;
                left_d   = instr_n;
            end else if (run_en && !halted_q) begin
                start_n = 1'b1;
                state_d = S_RUN;
            end
        end
        if (to_halt) state_d = S_HALT;
    end

    always_ff @(posedge clk12MHz) begin
        if (reset) begin
            state_q     <= S_CORE_RST;
            ph_q        <= PH_IDLE;
            cnt_q       <= '0;
            left_q      <= RST_N;
            stage_q     <= 3'd0;
            per_stage_q <= 3'd0;
            pc_q        <= 8'd0;
            out_q       <= 8'd0;
            tt_clk_q    <= 1'b0;
            tt_rst_n_q  <= 1'b0;
            halted_q    <= 1'b0;
            busy_q      <= 1'b1;
            rst_req_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            left_q  <= left_d;
            if (edge_d[2]) rst_req_q <= 1'b1;
            if (start_r)   rst_req_q <= 1'b0;

            if (start_r || start_n) begin
                ph_q     <= PH_HI;
                cnt_q    <= '0;
                tt_clk_q <= 1'b1;
                busy_q   <= 1'b1;
            end else if (to_halt) begin
                ph_q     <= PH_IDLE;
                cnt_q    <= '0;
                tt_clk_q <= 1'b0;
                busy_q   <= 1'b0;
            end else if (hi_end) begin
                ph_q     <= PH_LO;
                cnt_q    <= '0;
                tt_clk_q <= 1'b0;
                // release core reset in the low phase of the last reset period
                if (state_q == S_CORE_RST && left_q == LW'(1)) tt_rst_n_q <= 1'b1;
            end else if (ph_q != PH_IDLE) begin
                cnt_q <= cnt_q + CW'(1);
            end

            // stage advances on the tt_clk rising edge
            if (start_r) begin
                stage_q     <= 3'd0;
                per_stage_q <= 3'd0;
                tt_rst_n_q  <= 1'b0;
            end else if (start_n) begin
                per_stage_q <= stage_q;
                stage_q     <= stage_inc;
            end

            if (lo_end && per_stage_q == 3'd3) pc_q  <= tt_out;
            if (lo_end && per_stage_q == 3'd4) out_q <= tt_out;

            if (bp_hit) halted_q <= 1'b1;
            if (start_r || clr_halt) halted_q <= 1'b0;

            if (to_halt && state_q == S_CORE_RST) begin
                pc_q    <= 8'd0;
                out_q   <= 8'd0;
                stage_q <= 3'd0;
            end
        end
    end

    assign tt_clk   = tt_clk_q;
    assign tt_rst_n = tt_rst_n_q;
    assign stage    = stage_q;
    assign pc       = pc_q;
    assign out_val  = out_q;
    assign halted   = halted_q;
    assign busy     = busy_q;
endmodule

// File: doc/hova_clock_ctrl.md
Name: hova_clock_ctrl

Overview:
Generates the Hovalaag core's clock and reset (tt_clk, tt_rst_n) from the 12 MHz board clock. Supports four modes: free-run, single clock-period step, whole-instruction step and PC breakpoint halt. It mirrors the core's 5-stage sequence and captures PC (stage 3) and output (stage 4) from tt_out. It sits in the FPGA top between the buttons/LED display and the core, replacing the external tt_clk/tt_rst_n pins.

Parameters:
DIV, 6, clk12MHz cycles per tt_clk phase (high = low = DIV); DIV >= 2
RESET_CYCLES, 2, tt_clk periods with tt_rst_n held low during core reset
DEBOUNCE_BITS, 17, button lockout = 2^DEBOUNCE_BITS clk12MHz cycles

Ports:
clk12MHz  in  1  the only clock
reset  in  1  synchronous, active-high
run_en  in  1  level; free-run while high
step_btn  in  1  async button; one tt_clk period
instr_btn  in  1  async button; run to next stage-0 boundary
core_rst_btn  in  1  async button; re-run core reset sequence
bp_en  in  1  breakpoint enable
bp_pc  in  8  breakpoint PC
tt_out  in  8  core output bus
tt_clk  out  1  generated core clock, registered
tt_rst_n  out  1  core reset, active-low, registered
stage  out  3  mirrored core stage, 0..4
pc  out  8  last PC captured
out_val  out  8  last output captured
halted  out  1  breakpoint hit, sticky
busy  out  1  a tt_clk period or reset sequence is in progress

Behaviour:
- Period = DIV cycles tt_clk=1, then DIV cycles tt_clk=0. Periods start only from idle-low. A started period always completes; there are no runt pulses.
- Reset values: tt_clk=0, tt_rst_n=0, stage=0, pc=0, out_val=0, halted=0, busy=1. The FSM enters CORE_RST.
- Buttons: 2-flop synchroniser, then rising-edge detect. After an accepted edge, further edges on that button are ignored for 2^DEBOUNCE_BITS cycles.
- FSM states:
  - CORE_RST: tt_rst_n=0. Issues RESET_CYCLES periods. Then tt_rst_n=1 (set during the low phase of the last period), pc=0, out_val=0, stage=0 -> HALT.
  - HALT: tt_clk=0, busy=0.
    - step edge -> STEP with count=1.
    - instr edge -> STEP with count = (stage==0 ? 5 : 5-stage).
    - run_en=1 and halted=0 -> RUN.
  - STEP: issues count periods, then -> HALT. Any step, halt or button request clears halted on acceptance.
  - RUN: issues periods back to back. At a period boundary, -> HALT if run_en=0 or halted=1.
- Stage tracking, at the tt_clk rising edge:
  - tt_rst_n=0: stage <= 0.
  - otherwise: stage <= (stage==4) ? 0 : stage+1.
- Capture on the last cycle of the low phase, using the stage of that period:
  - stage==3: pc <= tt_out.
  - stage==4: out_val <= tt_out.
- Breakpoint: if bp_en=1 and the value written to pc equals bp_pc, halted <= 1 in the same cycle. RUN stops at that boundary (before the stage-4 period). STEP continues its count; halted stays 1.
- core_rst_btn has priority over all other requests. It is latched and taken at the next period boundary, or immediately if in HALT. It then enters CORE_RST and clears halted.
- Step/instr edges arriving while busy=1 are dropped.
- Block reset asserted mid-period: all outputs take reset values on the next cycle (tt_clk may drop early; this is accepted).
- busy=1 throughout CORE_RST, STEP and RUN periods.

Test Plan:
All scenarios use DIV=2, RESET_CYCLES=2, DEBOUNCE_BITS=3, with a core model that drives tt_out per stage.
1. Release reset -> tt_rst_n=0 for exactly 2 tt_clk rising edges, then 1. State HALT, tt_clk=0, stage=0, pc=0, busy=0.
2. step_btn pulse in HALT -> one tt_clk pulse (2 high, 2 low cycles). stage 0->1. busy=1 for 4 cycles.
3. stage=2, instr_btn, model drives 0x2A in stage 3 and 0x7E in stage 4 -> 3 pulses, stage=0, pc=0x2A, out_val=0x7E.
4. run_en=1, bp_en=1, bp_pc=0x05, model PC increments per instruction -> halt with pc=0x05, stage=4, halted=1, tt_clk low. Then step_btn -> halted=0, stage=0.
5. core_rst_btn during the high phase in RUN -> current period completes. Then 2 reset periods follow. stage=0, pc=0, out_val=0, HALT.
6. step_btn toggled 3 times within 8 cycles -> exactly one tt_clk period.
